seven_segment_message_scroller: RTL and testbench
=================================================

# seven_segment_message_scroller

Parametrised, time-multiplexed driver for a DIGITS-wide common-anode seven-segment display showing a message of up to MSG_DEPTH characters. A producer loads messages through a valid/ready write port into a double buffer. The block adds digit scanning, horizontal scrolling of messages longer than the display, and blanking blink. It sits between board-level control logic and the `abcdefgh`/`digit` pins.

## Interface
- `DIGITS`, 8: number of physical digits, 1..8.
- `MSG_DEPTH`, 16: maximum message length in characters, a power of 2 and at least DIGITS.
- `REFRESH_DIV`, 16: log2 of clock cycles per scanned digit.
- `SCROLL_DIV`, 24: log2 of clock cycles per scroll step.
- `BLINK_DIV`, 25: log2 of clock cycles per blink half-period.
- `clk`  in  1: system clock; the only clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `wr_valid`  in  1: character write request.
- `wr_ready`  out  1: write accepted when high together with wr_valid.
- `wr_char`  in  5: character code, from the shared package.
- `wr_last`  in  1: last character of the message; commits the message.
- `scroll_en`  in  1: enables scrolling; level-sensitive.
- `blink_en`  in  1: enables blinking; level-sensitive.
- `abcdefgh`  out  8: segments, MSB = a, LSB = h (dot). A 0 lights the segment.
- `digit`  out  DIGITS: digit enables. A 0 enables the digit.
- `busy`  out  1: high while a partial message is pending in the shadow buffer.

## Operation
- **Character codes:** 0–9 are the digits; 10 A, 11 b, 12 C, 13 d, 14 E, 15 F, 16 h, 17 I, 18 L, 19 n, 20 o, 21 P, 22 r, 23 t, 24 U, 25 y, 26 minus. Codes 27–31 are blank (8'hFF).
- **Example patterns:** C = 8'b01100011, E = 8'b01100001, h = 8'b11010001, I = 8'b11110011, P = 8'b00110001, minus = 8'b11111101. The dot is never lit.
- **Double buffer:** accepted writes fill the shadow buffer at wr_ptr, which then increments.
- **Commit:**
  - Triggered by an accepted write with wr_last = 1, or by an accepted write at wr_ptr = MSG_DEPTH-1.
  - On commit, shadow and active swap roles, len ← wr_ptr+1, offset ← 0 and wr_ptr ← 0.
  - wr_ready is low for exactly the one cycle after a commit and high otherwise.
- **busy:** equals (wr_ptr != 0).
- **Visible window:** character position p (0 = leftmost) drives digit bit DIGITS-1-p.
  - If scroll_en and len > DIGITS: position p shows active[(offset+p) mod len]. The window wraps circularly.
  - Otherwise: position p shows active[p] if p < len, else blank.
- **Scan:**
  - refresh_cnt (REFRESH_DIV bits) free-runs.
  - scan_idx advances 0→DIGITS-1→0 on each refresh_cnt wrap.
  - Exactly one digit bit is low at a time.
- **Scroll:**
  - scroll_cnt (SCROLL_DIV bits) free-runs.
  - On its wrap, if scroll_en and len > DIGITS, offset ← (offset+1 == len) ? 0 : offset+1.
  - Clearing scroll_en freezes nothing; the display reverts to the unscrolled view, but offset keeps its value.
- **Blink:**
  - blink_phase toggles on each BLINK_DIV-bit counter wrap.
  - If blink_en and blink_phase = 1: digit = all 1s and abcdefgh = 8'hFF.
- **Empty message:** len = 0 after reset. All positions are blank and scanning continues.

## Timing
- **Reset values (asynchronous):**
  - abcdefgh = 8'hFF, digit = all 1s, wr_ready = 0, busy = 0.
  - len = 0, offset = 0, wr_ptr = 0, all counters = 0, blink_phase = 0.
  - wr_ready rises on the first clk edge after reset_n deasserts.
- **Outputs are registered.** A change of scan_idx, offset, len or blink_phase appears on abcdefgh/digit exactly one cycle later.
- **Commit latency:** the new message is visible 1 cycle after the committing write edge, scan position permitting.
- **Simultaneous commit and scroll tick:** the commit wins and offset = 0.
- **Writes during display:** shadow writes never alter the visible output before commit.
- **Reset mid-operation:** a partial message is discarded and the active message is lost (len = 0).
- **wr_valid without wr_ready:** no state change; the producer must hold its data.

## Structure
- **Package `seven_segment_pkg`:**
  - character-code localparams, the `char_t` 5-bit type, and the 8-bit segment constants;
  - a function deriving counter and pointer widths via $clog2.
- **Sub-module `seven_segment_char_rom`:** a combinational code → abcdefgh decode, instantiated once on the selected character.
- **Top level:**
  - two MSG_DEPTH×5 register arrays with a buffer-select bit;
  - the write FSM, with states IDLE (wr_ptr = 0), FILL (wr_ptr ≠ 0) and COMMIT (single-cycle, wr_ready = 0);
  - the three counters and the output registers.

## Test plan
All scenarios use DIGITS=4, MSG_DEPTH=8, REFRESH_DIV=2, SCROLL_DIV=6, BLINK_DIV=8.
- **Reset:** assert reset_n = 0 mid-scan → abcdefgh = 8'hFF and digit = 4'b1111 immediately; wr_ready = 1 one edge after release.
- **Short message:** write C, h, I, P (last on P), scroll_en = 0.
  - Digits 4'b0111/1011/1101/1110 show 01100011/11010001/11110011/00110001 in turn.
  - Each digit holds for 4 cycles.
- **Long message:** write 6 characters E,C,E,C,E,P, then set scroll_en = 1.
  - After each 64-cycle tick the window shifts left by one.
  - After 6 ticks offset = 0 again, and the window wraps at position 5→0.
- **Auto-commit and handshake:**
  - Write 8 characters without wr_last → commit on the 8th; busy falls; wr_ready = 0 for 1 cycle.
  - Holding wr_valid across that cycle stalls the write exactly one cycle.
- **Blink:** blink_en = 1 → digit = 4'b1111 for 256 cycles, then normal scan for 256 cycles, repeating.
- **Commit vs. scroll tick:** commit on the same edge as a scroll tick → offset = 0 and the new first character appears on the leftmost digit.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment message scroller.
// Holds the 5-bit character codes, their active-low segment patterns
// (bit 7 = a ... bit 1 = g, bit 0 = h/dot), the write FSM state type and
// a width helper for counters and pointers.
package seven_segment_pkg;

    typedef logic [4:0] char_t;

    typedef enum logic [1:0] {StIdle, StFill, StCommit} wr_state_e;

    localparam char_t CHAR_0     = 5'd0;
    localparam char_t CHAR_1     = 5'd1;
    localparam char_t CHAR_2     = 5'd2;
    localparam char_t CHAR_3     = 5'd3;
    localparam char_t CHAR_4     = 5'd4;
    localparam char_t CHAR_5     = 5'd5;
    localparam char_t CHAR_6     = 5'd6;
    localparam char_t CHAR_7     = 5'd7;
    localparam char_t CHAR_8     = 5'd8;
    localparam char_t CHAR_9     = 5'd9;
    localparam char_t CHAR_A     = 5'd10;
    localparam char_t CHAR_B     = 5'd11;
    localparam char_t CHAR_C     = 5'd12;
    localparam char_t CHAR_D     = 5'd13;
    localparam char_t CHAR_E     = 5'd14;
    localparam char_t CHAR_F     = 5'd15;
    localparam char_t CHAR_H     = 5'd16;
    localparam char_t CHAR_I     = 5'd17;
    localparam char_t CHAR_L     = 5'd18;
    localparam char_t CHAR_N     = 5'd19;
    localparam char_t CHAR_O     = 5'd20;
    localparam char_t CHAR_P     = 5'd21;
    localparam char_t CHAR_R     = 5'd22;
    localparam char_t CHAR_T     = 5'd23;
    localparam char_t CHAR_U     = 5'd24;
    localparam char_t CHAR_Y     = 5'd25;
    localparam char_t CHAR_MINUS = 5'd26;
    localparam char_t CHAR_BLANK = 5'd31;

    // Active low: a 0 lights the segment. The dot is never lit.
    localparam logic [7:0] SEG_0     = 8'h03;
    localparam logic [7:0] SEG_1     = 8'h9F;
    localparam logic [7:0] SEG_2     = 8'h25;
    localparam logic [7:0] SEG_3     = 8'h0D;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h49;
    localparam logic [7:0] SEG_6     = 8'h41;
    localparam logic [7:0] SEG_7     = 8'h1F;
    localparam logic [7:0] SEG_8     = 8'h01;
    localparam logic [7:0] SEG_9     = 8'h09;
    localparam logic [7:0] SEG_A     = 8'h11;
    localparam logic [7:0] SEG_B     = 8'hC1;
    localparam logic [7:0] SEG_C     = 8'h63;
    localparam logic [7:0] SEG_D     = 8'h85;
    localparam logic [7:0] SEG_E     = 8'h61;
    localparam logic [7:0] SEG_F     = 8'h71;
    localparam logic [7:0] SEG_H     = 8'hD1;
    localparam logic [7:0] SEG_I     = 8'hF3;
    localparam logic [7:0] SEG_L     = 8'hE3;
    localparam logic [7:0] SEG_N     = 8'hD5;
    localparam logic [7:0] SEG_O     = 8'hC5;
    localparam logic [7:0] SEG_P     = 8'h31;
    localparam logic [7:0] SEG_R     = 8'hF5;
    localparam logic [7:0] SEG_T     = 8'hE1;
    localparam logic [7:0] SEG_U     = 8'h83;
    localparam logic [7:0] SEG_Y     = 8'h89;
    localparam logic [7:0] SEG_MINUS = 8'hFD;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Index width for n entries, never below one bit.
    function automatic int unsigned width_for(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seven_segment_char_rom.sv
// Combinational character decoder.
//   code : 5-bit character code
//   seg  : active-low segment pattern, MSB = a, LSB = h (dot, always off)
// Codes 27..31 decode to blank.
module seven_segment_char_rom
    import seven_segment_pkg::*;
(
    input  logic [4:0] code,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            CHAR_0:     seg = SEG_0;
            CHAR_1:     seg = SEG_1;
            CHAR_2:     seg = SEG_2;
            CHAR_3:     seg = SEG_3;
            CHAR_4:     seg = SEG_4;
            CHAR_5:     seg = SEG_5;
            CHAR_6:     seg = SEG_6;
            CHAR_7:     seg = SEG_7;
            CHAR_8:     seg = SEG_8;
            CHAR_9:     seg = SEG_9;
            CHAR_A:     seg = SEG_A;
            CHAR_B:     seg = SEG_B;
            CHAR_C:     seg = SEG_C;
            CHAR_D:     seg = SEG_D;
            CHAR_E:     seg = SEG_E;
            CHAR_F:     seg = SEG_F;
            CHAR_H:     seg = SEG_H;
            CHAR_I:     seg = SEG_I;
            CHAR_L:     seg = SEG_L;
            CHAR_N:     seg = SEG_N;
            CHAR_O:     seg = SEG_O;
            CHAR_P:     seg = SEG_P;
            CHAR_R:     seg = SEG_R;
            CHAR_T:     seg = SEG_T;
            CHAR_U:     seg = SEG_U;
            CHAR_Y:     seg = SEG_Y;
            CHAR_MINUS: seg = SEG_MINUS;
            default:    seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_segment_message_scroller.sv
// Time-multiplexed, scrolling, blinking driver for a common-anode
// seven-segment display fed from a double-buffered message store.
//   clk, reset_n        : clock, asynchronous active-low reset
//   wr_valid/wr_ready   : character write handshake
//   wr_char, wr_last    : character code; wr_last commits the message
//   scroll_en, blink_en : level-sensitive mode enables
//   abcdefgh, digit     : registered active-low segment / digit drives
//   busy                : a partial message sits in the shadow buffer
module seven_segment_message_scroller
    import seven_segment_pkg::*;
#(
    parameter int unsigned DIGITS      = 8,
    parameter int unsigned MSG_DEPTH   = 16,
    parameter int unsigned REFRESH_DIV = 16,
    parameter int unsigned SCROLL_DIV  = 24,
    parameter int unsigned BLINK_DIV   = 25
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [4:0]        wr_char,
    input  logic              wr_last,
    input  logic              scroll_en,
    input  logic              blink_en,
    output logic [7:0]        abcdefgh,
    output logic [DIGITS-1:0] digit,
    output logic              busy
);

    localparam int unsigned PTR_W = width_for(MSG_DEPTH);
    localparam int unsigned LEN_W = PTR_W + 1;
    localparam int unsigned IDX_W = width_for(DIGITS);

    wr_state_e               state_q, state_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [PTR_W-1:0]        offset_q, offset_d;
    logic                    sel_q;
    char_t                   buf_a [MSG_DEPTH];
    char_t                   buf_b [MSG_DEPTH];

    logic [REFRESH_DIV-1:0]  refresh_cnt_q;
    logic [IDX_W-1:0]        scan_idx_q, scan_idx_d;
    logic [SCROLL_DIV-1:0]   scroll_cnt_q;
    logic [BLINK_DIV-1:0]    blink_cnt_q;
    logic                    blink_phase_q;
    logic [7:0]              seg_q, seg_d;
    logic [DIGITS-1:0]       digit_q, digit_d;

    logic                    wr_accept, commit, scroll_tick, scrolling, pos_valid;
    logic [LEN_W-1:0]        pos_sum, pos_wrap;
    logic [PTR_W-1:0]        rd_idx;
    logic [IDX_W-1:0]        pos_rev;
    char_t                   rd_char, sel_char;
    logic [7:0]              sel_seg;

    // Write side: StCommit is the one cycle of back-pressure after a swap.
    // Reset enters it too, so wr_ready rises on the first edge out of reset.
    assign wr_ready  = (state_q != StCommit);
    assign wr_accept = wr_valid && wr_ready;
    assign commit    = wr_accept && (wr_last || (wr_ptr_q == PTR_W'(MSG_DEPTH - 1)));
    assign busy      = (wr_ptr_q != '0);

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        unique case (state_q)
            StIdle, StFill: begin
                if (commit) begin
                    state_d  = StCommit;
                    wr_ptr_d = '0;
                end else if (wr_accept) begin
                    state_d  = StFill;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
            end
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Shadow buffer is whichever array is not selected for display.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            if (sel_q) buf_a[wr_ptr_q] <= wr_char;
            else       buf_b[wr_ptr_q] <= wr_char;
        end
    end

    assign scroll_tick = (scroll_cnt_q == '1);
    assign scrolling   = scroll_en && (len_q > LEN_W'(DIGITS));

    always_comb begin
        len_d      = len_q;
        offset_d   = offset_q;
        scan_idx_d = scan_idx_q;
        if (refresh_cnt_q == '1) begin
            scan_idx_d = (scan_idx_q == IDX_W'(DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
        end
        // A commit on the same edge as a scroll tick restarts at offset 0.
        if (commit) begin
            len_d    = {1'b0, wr_ptr_q} + 1'b1;
            offset_d = '0;
        end else if (scroll_tick && scrolling) begin
            offset_d = (({1'b0, offset_q} + 1'b1) == len_q) ? '0 : offset_q + 1'b1;
        end
    end

    // Window: offset < len and scan_idx < DIGITS < len, so one subtract wraps.
    always_comb begin
        pos_sum   = {1'b0, offset_q} + LEN_W'(scan_idx_q);
        pos_wrap  = (pos_sum >= len_q) ? pos_sum - len_q : pos_sum;
        rd_idx    = scrolling ? PTR_W'(pos_wrap) : PTR_W'(scan_idx_q);
        pos_valid = scrolling || (LEN_W'(scan_idx_q) < len_q);
        rd_char   = sel_q ? buf_b[rd_idx] : buf_a[rd_idx];
        sel_char  = pos_valid ? rd_char : CHAR_BLANK;
    end

    seven_segment_char_rom u_char_rom (
        .code (sel_char),
        .seg  (sel_seg)
    );

    // Position 0 is the leftmost digit, i.e. the MSB of digit.
    always_comb begin
        pos_rev          = IDX_W'(DIGITS - 1) - scan_idx_q;
        digit_d          = '1;
        digit_d[pos_rev] = 1'b0;
        seg_d            = sel_seg;
        if (blink_en && blink_phase_q) begin
            digit_d = '1;
            seg_d   = SEG_BLANK;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StCommit;
            wr_ptr_q      <= '0;
            len_q         <= '0;
            offset_q      <= '0;
            sel_q         <= 1'b0;
            refresh_cnt_q <= '0;
            scan_idx_q    <= '0;
            scroll_cnt_q  <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            seg_q         <= SEG_BLANK;
            digit_q       <= '1;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            len_q         <= len_d;
            offset_q      <= offset_d;
            if (commit) sel_q <= ~sel_q;
            refresh_cnt_q <= refresh_cnt_q + 1'b1;
            scan_idx_q    <= scan_idx_d;
            scroll_cnt_q  <= scroll_cnt_q + 1'b1;
            blink_cnt_q   <= blink_cnt_q + 1'b1;
            if (blink_cnt_q == '1) blink_phase_q <= ~blink_phase_q;
            seg_q         <= seg_d;
            digit_q       <= digit_d;
        end
    end

    assign abcdefgh = seg_q;
    assign digit    = digit_q;

endmodule

// File: tb/tb_seven_segment_message_scroller.sv
module tb_seven_segment_message_scroller;

    localparam int unsigned DIGITS      = 4;
    localparam int unsigned MSG_DEPTH   = 8;
    localparam int unsigned REFRESH_DIV = 2;
    localparam int unsigned SCROLL_DIV  = 6;
    localparam int unsigned BLINK_DIV   = 8;
    localparam int REFRESH_CYC = 1 << REFRESH_DIV;
    localparam int SCROLL_CYC  = 1 << SCROLL_DIV;
    localparam int BLINK_CYC   = 1 << BLINK_DIV;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_last = 1'b0;
    logic       scroll_en = 1'b0;
    logic       blink_en = 1'b0;
    logic [4:0] wr_char = 5'd0;
    logic       wr_ready, busy;
    logic [7:0] abcdefgh;
    logic [3:0] digit;

    always #5 clk = ~clk;

    seven_segment_message_scroller #(
        .DIGITS      (DIGITS),
        .MSG_DEPTH   (MSG_DEPTH),
        .REFRESH_DIV (REFRESH_DIV),
        .SCROLL_DIV  (SCROLL_DIV),
        .BLINK_DIV   (BLINK_DIV)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_char   (wr_char),
        .wr_last   (wr_last),
        .scroll_en (scroll_en),
        .blink_en  (blink_en),
        .abcdefgh  (abcdefgh),
        .digit     (digit),
        .busy      (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Lit segments of each character, spelled out by segment letter.
    function automatic string lit_of(input int c);
        case (c)
            0: return "abcdef";   1: return "bc";      2: return "abdeg";
            3: return "abcdg";    4: return "bcfg";    5: return "acdfg";
            6: return "acdefg";   7: return "abc";     8: return "abcdefg";
            9: return "abcdfg";   10: return "abcefg"; 11: return "cdefg";
            12: return "adef";    13: return "bcdeg";  14: return "adefg";
            15: return "aefg";    16: return "cefg";   17: return "ef";
            18: return "def";     19: return "ceg";    20: return "cdeg";
            21: return "abefg";   22: return "eg";     23: return "defg";
            24: return "bcdef";   25: return "bcdfg";  26: return "g";
            default: return "";
        endcase
    endfunction

    function automatic logic [7:0] seg_of(input int c);
        string      s;
        logic [7:0] r;
        int         k;
        s = lit_of(c);
        r = 8'hFF;
        for (int i = 0; i < s.len(); i++) begin
            k = int'(s[i]) - 97;
            r[3'(7 - k)] = 1'b0;
        end
        return r;
    endfunction

    // Behavioural model: message queues plus time since reset.
    logic [4:0] act_msg[$];
    logic [4:0] shd_msg[$];
    int         off_m = 0;
    int         t_m = 0;
    bit         rdy_m = 1'b0;
    logic [7:0] exp_seg = 8'hFF;
    logic [3:0] exp_dig = 4'hF;
    bit         exp_rdy = 1'b0;
    bit         exp_busy = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                act_msg.delete();
                shd_msg.delete();
                off_m = 0;
                t_m   = 0;
                rdy_m = 1'b0;
                exp_seg = 8'hFF;
                exp_dig = 4'hF;
            end else begin : step
                int p, len, ch;
                bit scr, acc;
                len = act_msg.size();
                p   = (t_m / REFRESH_CYC) % DIGITS;
                scr = scroll_en && (len > DIGITS);
                if (scr)           ch = act_msg[(off_m + p) % len];
                else if (p < len)  ch = act_msg[p];
                else               ch = 31;
                if (blink_en && ((t_m / BLINK_CYC) % 2 == 1)) begin
                    exp_seg = 8'hFF;
                    exp_dig = 4'hF;
                end else begin
                    exp_seg = seg_of(ch);
                    exp_dig = ~(4'b1000 >> p);
                end
                if ((t_m % SCROLL_CYC == SCROLL_CYC - 1) && scr) off_m = (off_m + 1) % len;
                acc   = wr_valid && rdy_m;
                rdy_m = 1'b1;
                if (acc) begin
                    shd_msg.push_back(wr_char);
                    if (wr_last || shd_msg.size() == MSG_DEPTH) begin
                        act_msg = shd_msg;
                        shd_msg.delete();
                        off_m = 0;
                        rdy_m = 1'b0;
                    end
                end
                t_m++;
            end
            exp_rdy  = rdy_m;
            exp_busy = (shd_msg.size() != 0);
            @(negedge clk);
            if (!reset_n) begin
                exp_seg  = 8'hFF;
                exp_dig  = 4'hF;
                exp_rdy  = 1'b0;
                exp_busy = 1'b0;
            end
            chk("model_seg", abcdefgh, exp_seg);
            chk("model_digit", digit, exp_dig);
            chk("model_ready", wr_ready, exp_rdy);
            chk("model_busy", busy, exp_busy);
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic write_char(input int c, input bit last, output int waits);
        waits    = 0;
        wr_valid = 1'b1;
        wr_char  = 5'(c);
        wr_last  = last;
        while (!wr_ready && waits < 16) begin
            @(negedge clk);
            waits++;
        end
        chk("write_ready_seen", wr_ready, 1);
        @(negedge clk);
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic wait_digit(input logic [3:0] d, output bit found);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (digit == d) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int n, w;

        // Reset state and release
        repeat (3) @(negedge clk);
        chk("rst_seg", abcdefgh, 8'hFF);
        chk("rst_digit", digit, 4'hF);
        chk("rst_ready", wr_ready, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        #1 chk("ready_low_at_release", wr_ready, 0);
        @(negedge clk);
        chk("ready_after_release", wr_ready, 1);

        // Empty message: blank but still scanning
        repeat (16) @(negedge clk);
        wait_digit(4'b1101, found);
        chk("empty_scan_found", found, 1);
        chk("empty_blank", abcdefgh, 8'hFF);

        // Short message C h I P
        write_char(12, 0, w);
        write_char(16, 0, w);
        write_char(17, 0, w);
        write_char(21, 1, w);
        wait_digit(4'b0111, found);
        chk("short_d0_found", found, 1);
        chk("short_C", abcdefgh, 8'b01100011);
        wait_digit(4'b1011, found);
        chk("short_h", abcdefgh, 8'b11010001);
        n = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (digit != 4'b1011) break;
            n++;
        end
        chk("short_hold", n, 4);
        chk("short_d2", digit, 4'b1101);
        chk("short_I", abcdefgh, 8'b11110011);
        wait_digit(4'b1110, found);
        chk("short_P", abcdefgh, 8'b00110001);

        // Long message E C E C E P, scrolling
        write_char(14, 0, w);
        write_char(12, 0, w);
        write_char(14, 0, w);
        write_char(12, 0, w);
        write_char(14, 0, w);
        write_char(21, 1, w);
        scroll_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (digit == 4'b0111 && abcdefgh == 8'b00110001) begin
                found = 1'b1;
                break;
            end
        end
        chk("long_P_leftmost", found, 1);
        wait_digit(4'b1011, found);
        chk("long_wrap_E", abcdefgh, 8'b01100001);

        // Commit on the same edge as a scroll tick
        write_char(10, 0, w);
        write_char(11, 0, w);
        write_char(12, 0, w);
        write_char(13, 0, w);
        found = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (t_m % SCROLL_CYC == SCROLL_CYC - 1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("tick_align", found, 1);
        write_char(14, 1, w);
        wait_digit(4'b0111, found);
        chk("tick_commit_A", abcdefgh, 8'b00010001);
        wait_digit(4'b1011, found);
        chk("tick_commit_b", abcdefgh, 8'b11000001);

        // Auto-commit on the 8th character and the one-cycle stall
        for (int i = 0; i < 8; i++) begin
            write_char(i, 0, w);
            if (i == 2) chk("busy_partial", busy, 1);
            if (i == 7) chk("no_stall_8th", w, 0);
        end
        chk("autocommit_busy", busy, 0);
        chk("autocommit_ready", wr_ready, 0);
        write_char(9, 0, w);
        chk("stall_cycles", w, 1);
        chk("busy_after_stall", busy, 1);
        write_char(1, 1, w);

        // Blink
        scroll_en = 1'b0;
        blink_en  = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (digit != 4'hF) break;
        end
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (digit == 4'hF) begin
                found = 1'b1;
                break;
            end
        end
        chk("blink_off_found", found, 1);
        chk("blink_off_seg", abcdefgh, 8'hFF);
        n = 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (digit != 4'hF) break;
            n++;
        end
        chk("blink_off_len", n, 256);
        n = 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (digit == 4'hF) break;
            n++;
        end
        chk("blink_on_len", n, 256);
        blink_en = 1'b0;

        // Reset mid-operation with a partial message pending
        write_char(3, 0, w);
        chk("busy_before_reset", busy, 1);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_seg", abcdefgh, 8'hFF);
        chk("midrst_digit", digit, 4'hF);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", wr_ready, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1 chk("midrst_ready_release", wr_ready, 0);
        @(negedge clk);
        chk("midrst_ready_after", wr_ready, 1);
        write_char(2, 1, w);
        wait_digit(4'b0111, found);
        chk("after_reset_two", abcdefgh, 8'b00100101);
        wait_digit(4'b1011, found);
        chk("after_reset_blank", abcdefgh, 8'hFF);

        repeat (8) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
